// File: rtl/led_scan_sched_if.sv
// Timer-side bus of the LED scan scheduler.
// master drives the timer controls, slave is the interval timer.
interface led_scan_sched_if #(
    parameter int CW = 18
);
    logic          tmr_finish;
    logic          tmr_en;
    logic          tmr_clr;
    logic [CW-1:0] tmr_max;

    modport master (
        input  tmr_finish,
        output tmr_en,
        output tmr_clr,
        output tmr_max
    );

    modport slave (
        output tmr_finish,
        input  tmr_en,
        input  tmr_clr,
        input  tmr_max
    );
endinterface

// File: rtl/led_scan_sched.sv
// LED scan scheduler: sequences the interval timer and sweeps its period.
// Optional slot skipping with `define LED_SCAN_SLOT_MASK_EN.
module led_scan_sched #(
    parameter int SLOTS = 4,
    parameter int SEL_W = 2,
    parameter int CW    = 18
) (
    input  logic             clkSignal,
    input  logic             RST,
    input  logic             EN,
    input  logic [CW-1:0]    cfg_start,
    input  logic [CW-1:0]    cfg_step,
`ifdef LED_SCAN_SLOT_MASK_EN
    input  logic [SLOTS-1:0] slot_mask,
`endif
    led_scan_sched_if.master tmr,
    output logic [SEL_W-1:0] led_sel,
    output logic             round_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STEP
    } state_t;

    state_t        state;
    logic          fin_q;
    logic          fin_rise;
    logic [CW-1:0] reload;
    logic [CW-1:0] swept;

    assign fin_rise = tmr.tmr_finish & ~fin_q;
    assign reload   = (cfg_start == '0) ? CW'(1) : cfg_start;
    assign swept    = (tmr.tmr_max > cfg_step)
                    ? tmr.tmr_max - cfg_step
                    : reload;

`ifdef LED_SCAN_SLOT_MASK_EN
    logic             mask_any;
    logic             nxt_found;
    logic [SEL_W-1:0] nxt_idx;
    logic [SEL_W-1:0] low_idx;

    // Descending scans leave the lowest qualifying index behind.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        low_idx   = '0;
        mask_any  = |slot_mask;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_mask[i]) begin
                low_idx = SEL_W'(i);
                if (i > int'(led_sel)) begin
                    nxt_found = 1'b1;
                    nxt_idx   = SEL_W'(i);
                end
            end
        end
    end
`endif

    always_ff @(posedge clkSignal or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            fin_q       <= 1'b0;
            tmr.tmr_en  <= 1'b0;
            tmr.tmr_clr <= 1'b0;
            tmr.tmr_max <= '0;
            led_sel     <= '0;
            round_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fin_q <= tmr.tmr_finish;
            if (state != IDLE && !EN) begin
                state       <= IDLE;
                tmr.tmr_en  <= 1'b0;
                tmr.tmr_clr <= 1'b0;
                round_done  <= 1'b0;
                busy        <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (EN) begin
                            state       <= ARM;
                            tmr.tmr_max <= reload;
                            tmr.tmr_clr <= 1'b1;
                            busy        <= 1'b1;
`ifdef LED_SCAN_SLOT_MASK_EN
                            if (mask_any) led_sel <= low_idx;
`else
                            led_sel     <= '0;
`endif
                        end
                    end
                    ARM: begin
`ifdef LED_SCAN_SLOT_MASK_EN
                        if (!mask_any) begin
                            tmr.tmr_en  <= 1'b0;
                            tmr.tmr_clr <= 1'b0;
                        end else begin
                            state       <= RUN;
                            led_sel     <= low_idx;
                            tmr.tmr_clr <= 1'b0;
                            tmr.tmr_en  <= 1'b1;
                        end
`else
                        state       <= RUN;
                        tmr.tmr_clr <= 1'b0;
                        tmr.tmr_en  <= 1'b1;
`endif
                    end
                    RUN: begin
`ifdef LED_SCAN_SLOT_MASK_EN
                        if (!mask_any) begin
                            state       <= ARM;
                            tmr.tmr_en  <= 1'b0;
                            tmr.tmr_clr <= 1'b0;
                        end else if (fin_rise) begin
                            state       <= STEP;
                            tmr.tmr_en  <= 1'b0;
                            tmr.tmr_clr <= 1'b1;
                            if (nxt_found) begin
                                led_sel <= nxt_idx;
                            end else begin
                                led_sel     <= low_idx;
                                round_done  <= 1'b1;
                                tmr.tmr_max <= swept;
                            end
                        end
`else
                        if (fin_rise) begin
                            state       <= STEP;
                            tmr.tmr_en  <= 1'b0;
                            tmr.tmr_clr <= 1'b1;
                            if (led_sel != SEL_W'(SLOTS - 1)) begin
                                led_sel <= led_sel + 1'b1;
                            end else begin
                                led_sel     <= '0;
                                round_done  <= 1'b1;
                                tmr.tmr_max <= swept;
                            end
                        end
`endif
                    end
                    STEP: begin
                        tmr.tmr_clr <= 1'b0;
                        round_done  <= 1'b0;
`ifdef LED_SCAN_SLOT_MASK_EN
                        if (!mask_any) begin
                            state      <= ARM;
                            tmr.tmr_en <= 1'b0;
                        end else begin
                            state      <= RUN;
                            tmr.tmr_en <= 1'b1;
                        end
`else
                        state      <= RUN;
                        tmr.tmr_en <= 1'b1;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_scan_sched.sv
// Directed bench for led_scan_sched.
// Finish pulses are driven by hand; expected values are hand-computed.
module tb_led_scan_sched;

    localparam int CW    = 18;
    localparam int SEL_W = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] cfg_start;
    logic [CW-1:0] cfg_step;
    logic [SEL_W-1:0] led_sel;
    logic          round_done;
    logic          busy;
`ifdef LED_SCAN_SLOT_MASK_EN
    logic [3:0]    slot_mask;
`endif

    int total = 0;
    int bad   = 0;

    led_scan_sched_if #(.CW(CW)) tif ();

    led_scan_sched #(
        .SLOTS(4),
        .SEL_W(SEL_W),
        .CW   (CW)
    ) dut (
        .clkSignal (clk),
        .RST       (rst_n),
        .EN        (en),
        .cfg_start (cfg_start),
        .cfg_step  (cfg_step),
`ifdef LED_SCAN_SLOT_MASK_EN
        .slot_mask (slot_mask),
`endif
        .tmr       (tif.master),
        .led_sel   (led_sel),
        .round_done(round_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle finish pulse: RUN -> STEP -> RUN.
    task automatic fin(input logic [1:0] sel_exp, input logic rd_exp,
                       input int max_exp);
        tif.tmr_finish = 1'b1;
        step();
        tif.tmr_finish = 1'b0;
        chk("adv_sel", 32'(led_sel), 32'(sel_exp));
        chk("adv_rd", 32'(round_done), 32'(rd_exp));
        chk("adv_max", 32'(tif.tmr_max), 32'(max_exp));
        chk("adv_clr", 32'(tif.tmr_clr), 32'd1);
        chk("adv_en", 32'(tif.tmr_en), 32'd0);
        step();
        chk("step_en", 32'(tif.tmr_en), 32'd1);
        chk("step_rd", 32'(round_done), 32'd0);
    endtask

    task automatic round(input int max_exp);
        fin(2'd1, 1'b0, 0 + int'(tif.tmr_max));
        fin(2'd2, 1'b0, int'(tif.tmr_max));
        fin(2'd3, 1'b0, int'(tif.tmr_max));
        fin(2'd0, 1'b1, max_exp);
    endtask

    initial begin
        rst_n          = 1'b0;
        en             = 1'b0;
        cfg_start      = 18'd5;
        cfg_step       = 18'd1;
        tif.tmr_finish = 1'b0;
`ifdef LED_SCAN_SLOT_MASK_EN
        slot_mask      = 4'b1111;
`endif
        step();
        step();
        chk("rst_en", 32'(tif.tmr_en), 32'd0);
        chk("rst_max", 32'(tif.tmr_max), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Arm and first round 5 -> 4
        en = 1'b1;
        step();
        chk("arm_clr", 32'(tif.tmr_clr), 32'd1);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_en", 32'(tif.tmr_en), 32'd0);
        chk("arm_max", 32'(tif.tmr_max), 32'd5);
        chk("arm_sel", 32'(led_sel), 32'd0);
        step();
        chk("run_clr", 32'(tif.tmr_clr), 32'd0);
        chk("run_en", 32'(tif.tmr_en), 32'd1);
        round(4);
        round(3);
        round(2);
        round(1);
        round(5);

        // Held finish advances exactly once
        tif.tmr_finish = 1'b1;
        step();
        chk("held_sel0", 32'(led_sel), 32'd1);
        step();
        step();
        chk("held_sel2", 32'(led_sel), 32'd1);
        chk("held_en", 32'(tif.tmr_en), 32'd1);
        tif.tmr_finish = 1'b0;
        step();
        fin(2'd2, 1'b0, 5);

        // Enable drop holds sel/max
        en = 1'b0;
        step();
        chk("drop_en", 32'(tif.tmr_en), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_sel", 32'(led_sel), 32'd2);
        chk("drop_max", 32'(tif.tmr_max), 32'd5);
        tif.tmr_finish = 1'b1;
        step();
        tif.tmr_finish = 1'b0;
        step();
        chk("idle_fin_sel", 32'(led_sel), 32'd2);

        // Re-arm with cfg_start=0 -> interval forced to 1
        cfg_start = 18'd0;
        en = 1'b1;
        step();
        chk("rearm_sel", 32'(led_sel), 32'd0);
        chk("rearm_max", 32'(tif.tmr_max), 32'd1);
        step();
        round(1);

        // Mid-round cfg change only takes effect at reload
        cfg_start = 18'd9;
        fin(2'd1, 1'b0, 1);
        fin(2'd2, 1'b0, 1);
        fin(2'd3, 1'b0, 1);
        fin(2'd0, 1'b1, 9);
        cfg_step = 18'd4;
        round(5);
        round(1);

        // Async reset mid-run
        fin(2'd1, 1'b0, 1);
        fin(2'd2, 1'b0, 1);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("arst_sel", 32'(led_sel), 32'd0);
        chk("arst_en", 32'(tif.tmr_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_max", 32'(tif.tmr_max), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("arst_idle", 32'(busy), 32'd0);

`ifdef LED_SCAN_SLOT_MASK_EN
        cfg_start = 18'd5;
        cfg_step  = 18'd1;
        slot_mask = 4'b1010;
        en = 1'b1;
        step();
        step();
        chk("mask_arm_sel", 32'(led_sel), 32'd1);
        fin(2'd3, 1'b0, 5);
        fin(2'd1, 1'b1, 4);
        slot_mask = 4'b0000;
        step();
        chk("mask0_en", 32'(tif.tmr_en), 32'd0);
        chk("mask0_busy", 32'(busy), 32'd1);
        chk("mask0_sel", 32'(led_sel), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
